// File: rtl/ps2_pkg.sv
// Shared constants and code-FSM state encoding for the PS/2 ASCII decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT  = 8'h12;
    localparam logic [7:0] PS2_RSHIFT  = 8'h59;
    localparam logic [7:0] ASCII_ENTER = 8'h0A;

    typedef enum logic [1:0] {
        ST_BASE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } code_state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational scan-code set 2 to ASCII lookup: letters (shift-aware), digits,
// space, enter and backspace. hit is low for unmapped codes.
module ps2_scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       hit
);

    logic       is_letter;
    logic [4:0] letter;

    always_comb begin
        ascii     = '0;
        hit       = 1'b0;
        is_letter = 1'b0;
        letter    = '0;
        case (code)
            8'h1C: begin is_letter = 1'b1; letter = 5'd0;  end
            8'h32: begin is_letter = 1'b1; letter = 5'd1;  end
            8'h21: begin is_letter = 1'b1; letter = 5'd2;  end
            8'h23: begin is_letter = 1'b1; letter = 5'd3;  end
            8'h24: begin is_letter = 1'b1; letter = 5'd4;  end
            8'h2B: begin is_letter = 1'b1; letter = 5'd5;  end
            8'h34: begin is_letter = 1'b1; letter = 5'd6;  end
            8'h33: begin is_letter = 1'b1; letter = 5'd7;  end
            8'h43: begin is_letter = 1'b1; letter = 5'd8;  end
            8'h3B: begin is_letter = 1'b1; letter = 5'd9;  end
            8'h42: begin is_letter = 1'b1; letter = 5'd10; end
            8'h4B: begin is_letter = 1'b1; letter = 5'd11; end
            8'h3A: begin is_letter = 1'b1; letter = 5'd12; end
            8'h31: begin is_letter = 1'b1; letter = 5'd13; end
            8'h44: begin is_letter = 1'b1; letter = 5'd14; end
            8'h4D: begin is_letter = 1'b1; letter = 5'd15; end
            8'h15: begin is_letter = 1'b1; letter = 5'd16; end
            8'h2D: begin is_letter = 1'b1; letter = 5'd17; end
            8'h1B: begin is_letter = 1'b1; letter = 5'd18; end
            8'h2C: begin is_letter = 1'b1; letter = 5'd19; end
            8'h3C: begin is_letter = 1'b1; letter = 5'd20; end
            8'h2A: begin is_letter = 1'b1; letter = 5'd21; end
            8'h1D: begin is_letter = 1'b1; letter = 5'd22; end
            8'h22: begin is_letter = 1'b1; letter = 5'd23; end
            8'h35: begin is_letter = 1'b1; letter = 5'd24; end
            8'h1A: begin is_letter = 1'b1; letter = 5'd25; end
            8'h45: begin hit = 1'b1; ascii = 8'h30; end
            8'h16: begin hit = 1'b1; ascii = 8'h31; end
            8'h1E: begin hit = 1'b1; ascii = 8'h32; end
            8'h26: begin hit = 1'b1; ascii = 8'h33; end
            8'h25: begin hit = 1'b1; ascii = 8'h34; end
            8'h2E: begin hit = 1'b1; ascii = 8'h35; end
            8'h36: begin hit = 1'b1; ascii = 8'h36; end
            8'h3D: begin hit = 1'b1; ascii = 8'h37; end
            8'h3E: begin hit = 1'b1; ascii = 8'h38; end
            8'h46: begin hit = 1'b1; ascii = 8'h39; end
            8'h29: begin hit = 1'b1; ascii = 8'h20; end
            8'h5A: begin hit = 1'b1; ascii = ASCII_ENTER; end
            8'h66: begin hit = 1'b1; ascii = 8'h08; end
            default: ;
        endcase
        if (is_letter) begin
            hit   = 1'b1;
            ascii = (shift ? 8'h41 : 8'h61) + {3'b000, letter};
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard receiver: sync, 11-bit frame check, stall timeout, make/break code FSM.
// Define PS2_REPEAT_EN to let typematic repeats of a held key produce a pulse each time.
module ps2_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    output logic       frame_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]      sync_clk;
    logic [2:0]      sync_data;
    logic            fall;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [10:0]     frame_w;
    logic            frame_ok;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      code_q;
    logic            code_stb;

    assign fall     = sync_clk[2] & ~sync_clk[1];
    // frame_w[0] is the start bit, [8:1] data, [9] parity, [10] stop
    assign frame_w  = {sync_data[2], shreg};
    assign frame_ok = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_clk  <= '1;
            sync_data <= '1;
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            code_q    <= '0;
            code_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_clk  <= {sync_clk[1:0], ps2_clk};
            sync_data <= {sync_data[1:0], ps2_data};
            code_stb  <= 1'b0;
            frame_err <= 1'b0;
            // An edge takes priority over an expiring timeout on the same cycle
            if (fall) begin
                to_cnt <= '0;
                shreg  <= frame_w[10:1];
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        code_q   <= frame_w[8:1];
                        code_stb <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                bit_cnt   <= '0;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    code_state_t state, state_n;
    logic        lshift, lshift_n;
    logic        rshift, rshift_n;
    logic        emit;
    logic [7:0]  look_ascii;
    logic        look_hit;
`ifndef PS2_REPEAT_EN
    logic [7:0]  last_make, last_make_n;
`endif

    ps2_scan2ascii u_lookup (
        .code  (code_q),
        .shift (lshift | rshift),
        .ascii (look_ascii),
        .hit   (look_hit)
    );

    always_comb begin
        state_n  = state;
        lshift_n = lshift;
        rshift_n = rshift;
        emit     = 1'b0;
`ifndef PS2_REPEAT_EN
        last_make_n = last_make;
`endif
        if (code_stb) begin
            case (state)
                ST_BASE: begin
                    if (code_q == PS2_BREAK) begin
                        state_n = ST_BRK;
                    end else if (code_q == PS2_EXT) begin
                        state_n = ST_EXT;
                    end else if (code_q == PS2_LSHIFT) begin
                        lshift_n = 1'b1;
                    end else if (code_q == PS2_RSHIFT) begin
                        rshift_n = 1'b1;
                    end else begin
`ifdef PS2_REPEAT_EN
                        emit = look_hit;
`else
                        emit        = look_hit && (code_q != last_make);
                        last_make_n = code_q;
`endif
                    end
                end
                ST_BRK: begin
                    if (code_q == PS2_LSHIFT) lshift_n = 1'b0;
                    if (code_q == PS2_RSHIFT) rshift_n = 1'b0;
`ifndef PS2_REPEAT_EN
                    if (code_q == last_make) last_make_n = '0;
`endif
                    state_n = ST_BASE;
                end
                ST_EXT: begin
                    state_n = (code_q == PS2_BREAK) ? ST_EXT_BRK : ST_BASE;
                end
                default: begin
                    state_n = ST_BASE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BASE;
            lshift      <= 1'b0;
            rshift      <= 1'b0;
            ascii_out   <= '0;
            ascii_valid <= 1'b0;
`ifndef PS2_REPEAT_EN
            last_make   <= '0;
`endif
        end else begin
            state       <= state_n;
            lshift      <= lshift_n;
            rshift      <= rshift_n;
            ascii_valid <= emit;
            if (emit) ascii_out <= look_ascii;
`ifndef PS2_REPEAT_EN
            last_make   <= last_make_n;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Self-checking bench for ps2_ascii_decoder: directed vector table, hand sequences
// for timeout / reset-mid-frame, then random codes against a keyboard-level model.
module tb_ps2_ascii_decoder;

    localparam int TO = 300;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       frame_err;

    ps2_ascii_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ascii_out   (ascii_out),
        .ascii_valid (ascii_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    int err_cnt = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ascii_valid) begin
            got_q.push_back(ascii_out);
            valid_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit (got %0d tests, required completion)", tests);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] c, input bit bad);
        logic p;
        p = (~^c) ^ bad;
        return {1'b1, p, c, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = b[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Keyboard-level reference model
    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    bit m_brk, m_ext, m_lsh, m_rsh;
    logic [7:0] m_held, m_last;

    function automatic bit lookup(input logic [7:0] c, input bit sh, output logic [7:0] ch);
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (c == letter_codes[i]) begin
                ch = (sh ? 8'd65 : 8'd97) + 8'(i);
                return 1'b1;
            end
        for (int i = 0; i < 10; i++)
            if (c == digit_codes[i]) begin
                ch = 8'd48 + 8'(i);
                return 1'b1;
            end
        if (c == 8'h29) begin ch = 8'h20; return 1'b1; end
        if (c == 8'h5A) begin ch = 8'h0A; return 1'b1; end
        if (c == 8'h66) begin ch = 8'h08; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0; m_held = 8'h00; m_last = 8'h00;
    endfunction

    function automatic void model(input logic [7:0] c, output bit v, output logic [7:0] a);
        bit mapped;
        v = 0;
        a = m_last;
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (c == 8'hF0) m_brk = 1; else m_ext = 0;
        end else if (m_brk) begin
            if (c == 8'h12) m_lsh = 0;
            if (c == 8'h59) m_rsh = 0;
            if (c == m_held) m_held = 8'h00;
            m_brk = 0;
        end else if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_ext = 1;
        else if (c == 8'h12) m_lsh = 1;
        else if (c == 8'h59) m_rsh = 1;
        else begin
            mapped = lookup(c, m_lsh | m_rsh, a);
`ifdef PS2_REPEAT_EN
            v = mapped;
`else
            v = mapped && (c != m_held);
            m_held = c;
`endif
            if (v) m_last = a; else a = m_last;
        end
    endfunction

    typedef struct {
        logic [7:0] code;
        bit         bad;
        bit         exp_v;
        logic [7:0] exp_a;
        bit         exp_e;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [7:0] c, input bit bad, input bit v,
                                input logic [7:0] a, input bit e);
        vec_t t;
        t.code = c; t.bad = bad; t.exp_v = v; t.exp_a = a; t.exp_e = e;
        vecs.push_back(t);
    endfunction

    bit rep;
    logic [7:0] last_a;
    logic [7:0] pool[16] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66,
        8'h12, 8'h59, 8'hF0, 8'hE0, 8'h05, 8'h75, 8'h1C, 8'hF0};

    initial begin
`ifdef PS2_REPEAT_EN
        rep = 1'b1;
`else
        rep = 1'b0;
`endif
        add(8'h1C, 0, 1, 8'h61, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h1C, 0, 0, 8'h00, 0);
        add(8'h12, 0, 0, 8'h00, 0); add(8'h1C, 0, 1, 8'h41, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h1C, 0, 0, 8'h00, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h12, 0, 0, 8'h00, 0);
        add(8'h1C, 0, 1, 8'h61, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h1C, 0, 0, 8'h00, 0);
        add(8'h5A, 0, 1, 8'h0A, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h5A, 0, 0, 8'h00, 0);
        add(8'h29, 0, 1, 8'h20, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h29, 0, 0, 8'h00, 0);
        add(8'h12, 0, 0, 8'h00, 0); add(8'h45, 0, 1, 8'h30, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h45, 0, 0, 8'h00, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h12, 0, 0, 8'h00, 0);
        add(8'h59, 0, 0, 8'h00, 0); add(8'h1C, 0, 1, 8'h41, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h1C, 0, 0, 8'h00, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h59, 0, 0, 8'h00, 0);
        add(8'h66, 0, 1, 8'h08, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h66, 0, 0, 8'h00, 0);
        add(8'h05, 0, 0, 8'h00, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h05, 0, 0, 8'h00, 0);
        add(8'h1C, 1, 0, 8'h00, 1); add(8'h1C, 0, 1, 8'h61, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h1C, 0, 0, 8'h00, 0);
        add(8'hE0, 0, 0, 8'h00, 0); add(8'h75, 0, 0, 8'h00, 0);
        add(8'hE0, 0, 0, 8'h00, 0); add(8'hF0, 0, 0, 8'h00, 0); add(8'h75, 0, 0, 8'h00, 0);
        add(8'h1C, 0, 1, 8'h61, 0);
        add(8'h1C, 0, rep, 8'h61, 0); add(8'h1C, 0, rep, 8'h61, 0);
        add(8'hF0, 0, 0, 8'h00, 0); add(8'h1C, 0, 0, 8'h00, 0);

        do_reset();
        check("reset_ascii_out", ascii_out, 0);
        check("reset_ascii_valid", ascii_valid, 0);
        check("reset_frame_err", frame_err, 0);
        last_a = 8'h00;

        foreach (vecs[i]) begin
            int e0;
            e0 = err_cnt;
            got_q.delete();
            send_bits(mk(vecs[i].code, vecs[i].bad), 11);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_code%0h_pulses", i, vecs[i].code), got_q.size(), int'(vecs[i].exp_v));
            if (vecs[i].exp_v && got_q.size() == 1) begin
                check($sformatf("v%0d_ascii", i), got_q[0], vecs[i].exp_a);
                check($sformatf("v%0d_valid_latency", i), valid_cyc - stop_cyc, 4);
                last_a = vecs[i].exp_a;
            end
            check($sformatf("v%0d_frame_err", i), err_cnt - e0, int'(vecs[i].exp_e));
            if (vecs[i].exp_e) check($sformatf("v%0d_err_latency", i), err_cyc - stop_cyc, 3);
            check($sformatf("v%0d_hold", i), ascii_out, last_a);
        end

        // Stalled frame: 5 bits then silence
        begin
            int e0;
            e0 = err_cnt;
            got_q.delete();
            send_bits(mk(8'h1C, 0), 5);
            repeat (TO + 60) @(negedge clk);
            check("timeout_err_pulses", err_cnt - e0, 1);
            check("timeout_no_valid", got_q.size(), 0);
            send_bits(mk(8'h32, 0), 11);
            repeat (4) @(negedge clk);
            check("after_timeout_pulses", got_q.size(), 1);
            if (got_q.size() == 1) check("after_timeout_ascii", got_q[0], 8'h62);
            check("after_timeout_err", err_cnt - e0, 1);
        end

        // Reset in the middle of a frame
        begin
            int e0;
            e0 = err_cnt;
            got_q.delete();
            send_bits(mk(8'h1C, 0), 6);
            do_reset();
            repeat (TO + 20) @(negedge clk);
            check("midreset_no_valid", got_q.size(), 0);
            check("midreset_no_err", err_cnt - e0, 0);
            check("midreset_ascii_out", ascii_out, 0);
            send_bits(mk(8'h1C, 0), 11);
            repeat (4) @(negedge clk);
            check("midreset_next_pulses", got_q.size(), 1);
            if (got_q.size() == 1) check("midreset_next_ascii", got_q[0], 8'h61);
        end

        // Random codes against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] c;
            logic [7:0] a;
            bit bad, v;
            int e0;
            c = pool[$urandom_range(0, 15)];
            bad = ($urandom_range(0, 9) == 0);
            e0 = err_cnt;
            got_q.delete();
            send_bits(mk(c, bad), 11);
            repeat (4) @(negedge clk);
            if (bad) begin
                v = 0;
                a = m_last;
            end else begin
                model(c, v, a);
            end
            check($sformatf("r%0d_code%0h_pulses", n, c), got_q.size(), int'(v));
            if (v && got_q.size() == 1) check($sformatf("r%0d_ascii", n), got_q[0], a);
            check($sformatf("r%0d_frame_err", n), err_cnt - e0, int'(bad));
            check($sformatf("r%0d_hold", n), ascii_out, m_last);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
